// File: rtl/spiflash_pkg.sv
// Shared types and constants for the single-lane SPI flash read master.
// The transaction frame is command, address, then data, all MSB first.
package spiflash_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    RESP  = 2'd2,
    GAP   = 2'd3
  } state_t;

  localparam logic [7:0] CMD_READ = 8'h03;

  localparam int CMD_BITS   = 8;
  localparam int ADDR_BITS  = 24;
  localparam int DATA_BITS  = 32;
  localparam int TOTAL_BITS = CMD_BITS + ADDR_BITS + DATA_BITS;

  // Bytes arrive first-byte-first in rx[31:24]; the response is little-endian.
  function automatic logic [DATA_BITS-1:0] le_word(input logic [DATA_BITS-1:0] rx);
    return {rx[7:0], rx[15:8], rx[23:16], rx[31:24]};
  endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SPI mode-0 clock generator: each half-phase lasts CLK_DIV system clocks.
// Strobes are high in the cycle whose closing edge raises or lowers flash_clk.
module spi_sclk_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  output logic flash_clk,
  output logic rise_stb,
  output logic fall_stb
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] RELOAD = DW'(CLK_DIV - 1);

  logic [DW-1:0] cnt;
  logic          half_end;

  assign half_end = enable && (cnt == '0);
  assign rise_stb = half_end && !flash_clk;
  assign fall_stb = half_end && flash_clk;

  // Counter parks at RELOAD while disabled so the first low phase is full length.
  always_ff @(posedge clock) begin
    if (reset || !enable) begin
      cnt       <= RELOAD;
      flash_clk <= 1'b0;
    end else if (half_end) begin
      cnt       <= RELOAD;
      flash_clk <= !flash_clk;
    end else begin
      cnt       <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/spiflash_read_master.sv
// SPI flash read master: one READ (0x03) frame per request, returning a
// 32-bit little-endian word from four consecutive flash bytes.
//
// state | meaning
// IDLE  | csb high, ready to accept a request
// SHIFT | csb low, 64 SCK cycles: command, address, data
// RESP  | response word presented until the consumer takes it
// GAP   | csb held high for CS_IDLE clocks before the next frame
module spiflash_read_master
  import spiflash_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int CS_IDLE = 2,
  parameter int ADDR_W  = 24
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_data,
  output logic              busy,
  output logic              flash_csb,
  output logic              flash_clk,
  output logic              flash_io0,
  input  logic              flash_io1
);

  localparam int BW = $clog2(TOTAL_BITS);
  localparam int GW = (CS_IDLE > 1) ? $clog2(CS_IDLE) : 1;
  localparam logic [BW-1:0] LAST_BIT   = BW'(TOTAL_BITS - 1);
  localparam logic [BW-1:0] DATA_START = BW'(CMD_BITS + ADDR_BITS);
  localparam logic [GW-1:0] GAP_LOAD   = GW'(CS_IDLE - 1);

  state_t                  state, state_nxt;
  logic [TOTAL_BITS-1:0]   shreg;
  logic [DATA_BITS-1:0]    rx;
  logic [DATA_BITS-1:0]    data_q;
  logic [BW-1:0]           bit_cnt;
  logic [GW-1:0]           gap_cnt;
  logic                    csb_q;
  logic                    sclk_en;
  logic                    rise_stb;
  logic                    fall_stb;
  logic                    last_fall;

  assign sclk_en   = (state == SHIFT);
  assign last_fall = fall_stb && (bit_cnt == LAST_BIT);

  spi_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .clock     (clock),
    .reset     (reset),
    .enable    (sclk_en),
    .flash_clk (flash_clk),
    .rise_stb  (rise_stb),
    .fall_stb  (fall_stb)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    busy      = (state != IDLE);
    unique case (state)
      IDLE: begin
        req_ready = !reset;
        if (req_valid) state_nxt = SHIFT;
      end
      SHIFT: begin
        if (last_fall) state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = GAP;
      end
      GAP: begin
        if (gap_cnt == '0) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // io0 is the shift register MSB; zeros shifted in make the data phase drive 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      shreg   <= '0;
      rx      <= '0;
      data_q  <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
      csb_q   <= 1'b1;
    end else begin
      csb_q <= (state_nxt != SHIFT);
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            shreg   <= {CMD_READ, req_addr, {DATA_BITS{1'b0}}};
            bit_cnt <= '0;
          end
        end
        SHIFT: begin
          if (rise_stb && (bit_cnt >= DATA_START)) rx <= {rx[DATA_BITS-2:0], flash_io1};
          if (fall_stb) begin
            shreg   <= {shreg[TOTAL_BITS-2:0], 1'b0};
            bit_cnt <= bit_cnt + 1'b1;
          end
          if (last_fall) data_q <= le_word(rx);
        end
        RESP: begin
          if (rsp_ready) gap_cnt <= GAP_LOAD;
        end
        GAP: begin
          if (gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign flash_csb = csb_q;
  assign flash_io0 = shreg[TOTAL_BITS-1];
  assign rsp_data  = data_q;

endmodule

// File: tb/tb_spiflash_read_master.sv
// Directed bench for spiflash_read_master: three instances (CLK_DIV 2, 1, 5)
// each talking to a small behavioural flash model sampled on the falling clock.
module tb_spiflash_read_master;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid [3];
  logic [23:0] req_addr  [3];
  logic        rsp_ready [3];
  logic        req_ready [3];
  logic        rsp_valid [3];
  logic [31:0] rsp_data  [3];
  logic        busy      [3];
  logic        flash_csb [3];
  logic        flash_clk [3];
  logic        flash_io0 [3];
  logic [7:0]  mem [0:1023];

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  for (genvar g = 0; g < 3; g++) begin : gen_i
    localparam int DIV = (g == 0) ? 2 : (g == 1) ? 1 : 5;
    logic        io1 = 1'b0;
    logic [31:0] cap = '0;
    logic [7:0]  cmd_cap = '0;
    logic [23:0] addr_cap = '0;
    logic [7:0]  cur_byte;
    logic        prev_clk = 1'b0;
    logic        prev_csb = 1'b1;
    int bits = 0, rises = 0, run = 0, high_run = 0, last_gap = 0, d = 0;
    int hi_min = 1000, hi_max = 0, lo_min = 1000, lo_max = 0;

    spiflash_read_master #(
      .CLK_DIV (DIV),
      .CS_IDLE (2),
      .ADDR_W  (24)
    ) u_dut (
      .clock     (clock),
      .reset     (reset),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_addr  (req_addr[g]),
      .rsp_valid (rsp_valid[g]),
      .rsp_ready (rsp_ready[g]),
      .rsp_data  (rsp_data[g]),
      .busy      (busy[g]),
      .flash_csb (flash_csb[g]),
      .flash_clk (flash_clk[g]),
      .flash_io0 (flash_io0[g]),
      .flash_io1 (io1)
    );

    // Flash responder: samples io0 after SCK rises, drives io1 after SCK falls.
    always @(negedge clock) begin
      if (flash_csb[g]) begin
        high_run++;
        run = 0;
      end else begin
        if (prev_csb) begin
          last_gap = high_run; high_run = 0; bits = 0; rises = 0; run = 0;
          hi_min = 1000; hi_max = 0; lo_min = 1000; lo_max = 0;
        end
        if (flash_clk[g] != prev_clk) begin
          if (flash_clk[g]) begin
            if (run < lo_min) lo_min = run;
            if (run > lo_max) lo_max = run;
            cap = {cap[30:0], flash_io0[g]};
            bits++; rises++;
            if (bits == 32) begin cmd_cap = cap[31:24]; addr_cap = cap[23:0]; end
          end else begin
            if (run < hi_min) hi_min = run;
            if (run > hi_max) hi_max = run;
            if (bits >= 32 && bits < 64) begin
              d = bits - 32;
              cur_byte = mem[(int'(addr_cap) + d / 8) & 1023];
              io1 = cur_byte[7 - (d % 8)];
            end
          end
          run = 1;
        end else begin
          run++;
        end
      end
      prev_clk = flash_clk[g];
      prev_csb = flash_csb[g];
    end
  end

  task automatic do_read(input int i, input logic [23:0] a, output int lat,
                         output logic [31:0] d, output bit ok);
    ok = 1'b0; lat = 0; d = '0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clock);
      if (req_ready[i]) break;
    end
    if (!req_ready[i]) return;
    req_addr[i] = a; req_valid[i] = 1'b1; rsp_ready[i] = 1'b1;
    @(posedge clock);
    for (int n = 0; n < 2000; n++) begin
      @(negedge clock);
      lat++;
      req_valid[i] = 1'b0;
      if (rsp_valid[i]) begin d = rsp_data[i]; ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    checks++; if (flash_csb[0] !== 1'b1) begin failures++; $display("FAIL reset_csb: got %b expected 1", flash_csb[0]); end
    checks++; if (flash_clk[0] !== 1'b0) begin failures++; $display("FAIL reset_clk: got %b expected 0", flash_clk[0]); end
    checks++; if (flash_io0[0] !== 1'b0) begin failures++; $display("FAIL reset_io0: got %b expected 0", flash_io0[0]); end
    checks++; if (rsp_valid[0] !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid[0]); end
    checks++; if (rsp_data[0] !== 32'h0) begin failures++; $display("FAIL reset_rsp_data: got %h expected 00000000", rsp_data[0]); end
    checks++; if (busy[0] !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy[0]); end
    checks++; if (req_ready[0] !== 1'b0) begin failures++; $display("FAIL reset_req_ready: got %b expected 0", req_ready[0]); end
    reset = 1'b0;
    @(negedge clock);
    checks++; if (req_ready[0] !== 1'b1) begin failures++; $display("FAIL idle_req_ready: got %b expected 1", req_ready[0]); end
  endtask

  task automatic test_single_read();
    int lat; logic [31:0] d; bit ok;
    do_read(0, 24'h000000, lat, d, ok);
    checks++; if (!ok) begin failures++; $display("FAIL single_timeout: no response seen"); end
    checks++; if (lat !== 257) begin failures++; $display("FAIL single_latency: got %0d expected 257", lat); end
    checks++; if (d !== 32'h0B00006F) begin failures++; $display("FAIL single_data: got %h expected 0b00006f", d); end
    checks++; if (gen_i[0].cmd_cap !== 8'h03) begin failures++; $display("FAIL single_cmd: got %h expected 03", gen_i[0].cmd_cap); end
    checks++; if (gen_i[0].addr_cap !== 24'h000000) begin failures++; $display("FAIL single_addr: got %h expected 000000", gen_i[0].addr_cap); end
    checks++; if (gen_i[0].rises !== 64) begin failures++; $display("FAIL single_sck_count: got %0d expected 64", gen_i[0].rises); end
    checks++; if (gen_i[0].hi_min !== 2 || gen_i[0].hi_max !== 2 || gen_i[0].lo_min !== 2 || gen_i[0].lo_max !== 2) begin
      failures++; $display("FAIL single_sck_width: hi %0d..%0d lo %0d..%0d expected all 2",
                           gen_i[0].hi_min, gen_i[0].hi_max, gen_i[0].lo_min, gen_i[0].lo_max); end
  endtask

  task automatic test_unaligned();
    int lat; logic [31:0] d; bit ok;
    do_read(0, 24'h0001F5, lat, d, ok);
    checks++; if (!ok) begin failures++; $display("FAIL unaligned_timeout: no response seen"); end
    checks++; if (d !== 32'h44332211) begin failures++; $display("FAIL unaligned_data: got %h expected 44332211", d); end
    checks++; if (gen_i[0].addr_cap !== 24'h0001F5) begin failures++; $display("FAIL unaligned_addr: got %h expected 0001f5", gen_i[0].addr_cap); end
    checks++; if (gen_i[0].cmd_cap !== 8'h03) begin failures++; $display("FAIL unaligned_cmd: got %h expected 03", gen_i[0].cmd_cap); end
  endtask

  task automatic test_backpressure();
    int bad, n; bit seen;
    for (int k = 0; k < 100; k++) begin @(negedge clock); if (req_ready[0]) break; end
    req_addr[0] = 24'h000010; req_valid[0] = 1'b1; rsp_ready[0] = 1'b0;
    @(posedge clock);
    seen = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clock);
      req_valid[0] = 1'b0;
      if (rsp_valid[0]) begin seen = 1'b1; break; end
    end
    checks++; if (!seen) begin failures++; $display("FAIL bp_timeout: no response seen"); end
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      if (k > 0) @(negedge clock);
      if (rsp_valid[0] !== 1'b1 || rsp_data[0] !== 32'hD4C3B2A1 || flash_csb[0] !== 1'b1 ||
          flash_clk[0] !== 1'b0 || req_ready[0] !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL bp_hold: %0d bad cycles, data %h expected d4c3b2a1 held", bad, rsp_data[0]); end
    rsp_ready[0] = 1'b1; req_addr[0] = 24'h000020; req_valid[0] = 1'b1;
    @(posedge clock);
    @(negedge clock);
    checks++; if (rsp_valid[0] !== 1'b0 || busy[0] !== 1'b1) begin failures++; $display("FAIL bp_release: rsp_valid %b busy %b expected 0 1", rsp_valid[0], busy[0]); end
    n = 1;
    while (!req_ready[0] && n < 50) begin @(negedge clock); n++; end
    checks++; if (n !== 3) begin failures++; $display("FAIL bp_next_accept: got %0d clocks expected 3", n); end
    @(posedge clock);
    seen = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clock);
      req_valid[0] = 1'b0;
      if (rsp_valid[0]) begin seen = 1'b1; break; end
    end
    checks++; if (!seen || rsp_data[0] !== 32'h67452301) begin failures++; $display("FAIL bp_second_data: got %h expected 67452301", rsp_data[0]); end
  endtask

  task automatic test_back_to_back();
    logic [23:0] addrs [3];
    logic [31:0] exp_d [3];
    int idx, nrsp; bit adv;
    addrs[0] = 24'h000010; addrs[1] = 24'h000033; addrs[2] = 24'h0001F5;
    exp_d[0] = 32'hD4C3B2A1; exp_d[1] = 32'h98BADCFE; exp_d[2] = 32'h44332211;
    for (int k = 0; k < 100; k++) begin @(negedge clock); if (req_ready[0]) break; end
    idx = 0; nrsp = 0; adv = 1'b0;
    req_addr[0] = addrs[0]; req_valid[0] = 1'b1; rsp_ready[0] = 1'b1;
    for (int n = 0; n < 3000 && nrsp < 3; n++) begin
      if (adv) begin
        idx++; adv = 1'b0;
        if (idx < 3) req_addr[0] = addrs[idx]; else req_valid[0] = 1'b0;
      end
      if (rsp_valid[0]) begin
        checks++; if (rsp_data[0] !== exp_d[nrsp]) begin failures++; $display("FAIL b2b_data%0d: got %h expected %h", nrsp, rsp_data[0], exp_d[nrsp]); end
        checks++; if (gen_i[0].rises !== 64) begin failures++; $display("FAIL b2b_sck%0d: got %0d expected 64", nrsp, gen_i[0].rises); end
        if (nrsp > 0) begin
          checks++; if (gen_i[0].last_gap < 3) begin failures++; $display("FAIL b2b_gap%0d: got %0d expected >= 3", nrsp, gen_i[0].last_gap); end
        end
        nrsp++;
      end
      if (req_valid[0] && req_ready[0]) adv = 1'b1;
      @(negedge clock);
    end
    req_valid[0] = 1'b0;
    checks++; if (nrsp !== 3) begin failures++; $display("FAIL b2b_count: got %0d responses expected 3", nrsp); end
  endtask

  task automatic test_reset_mid();
    int lat, extra; logic [31:0] d; bit ok;
    for (int k = 0; k < 100; k++) begin @(negedge clock); if (req_ready[0]) break; end
    req_addr[0] = 24'h0001F5; req_valid[0] = 1'b1; rsp_ready[0] = 1'b1;
    @(posedge clock);
    @(negedge clock);
    req_valid[0] = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      if (gen_i[0].rises == 40) break;
      @(negedge clock);
    end
    checks++; if (gen_i[0].rises !== 40) begin failures++; $display("FAIL mid_reach40: got %0d SCK rises expected 40", gen_i[0].rises); end
    reset = 1'b1;
    @(negedge clock);
    checks++; if (flash_csb[0] !== 1'b1 || flash_clk[0] !== 1'b0) begin failures++; $display("FAIL mid_reset_pins: csb %b clk %b expected 1 0", flash_csb[0], flash_clk[0]); end
    checks++; if (rsp_valid[0] !== 1'b0 || busy[0] !== 1'b0) begin failures++; $display("FAIL mid_reset_state: rsp_valid %b busy %b expected 0 0", rsp_valid[0], busy[0]); end
    reset = 1'b0;
    extra = 0;
    for (int k = 0; k < 300; k++) begin @(negedge clock); if (rsp_valid[0]) extra++; end
    checks++; if (extra !== 0) begin failures++; $display("FAIL mid_no_response: got %0d response cycles expected 0", extra); end
    do_read(0, 24'h000020, lat, d, ok);
    checks++; if (!ok || d !== 32'h67452301) begin failures++; $display("FAIL mid_after_data: got %h expected 67452301", d); end
    checks++; if (lat !== 257) begin failures++; $display("FAIL mid_after_latency: got %0d expected 257", lat); end
  endtask

  task automatic test_clk_div();
    int lat; logic [31:0] d; bit ok;
    do_read(1, 24'h000010, lat, d, ok);
    checks++; if (!ok || d !== 32'hD4C3B2A1) begin failures++; $display("FAIL div1_data: got %h expected d4c3b2a1", d); end
    checks++; if (lat !== 129) begin failures++; $display("FAIL div1_latency: got %0d expected 129", lat); end
    checks++; if (gen_i[1].hi_min !== 1 || gen_i[1].hi_max !== 1 || gen_i[1].lo_min !== 1 || gen_i[1].lo_max !== 1) begin
      failures++; $display("FAIL div1_sck_width: hi %0d..%0d lo %0d..%0d expected all 1",
                           gen_i[1].hi_min, gen_i[1].hi_max, gen_i[1].lo_min, gen_i[1].lo_max); end
    checks++; if (gen_i[1].rises !== 64) begin failures++; $display("FAIL div1_sck_count: got %0d expected 64", gen_i[1].rises); end
    do_read(2, 24'h000033, lat, d, ok);
    checks++; if (!ok || d !== 32'h98BADCFE) begin failures++; $display("FAIL div5_data: got %h expected 98badcfe", d); end
    checks++; if (lat !== 641) begin failures++; $display("FAIL div5_latency: got %0d expected 641", lat); end
    checks++; if (gen_i[2].hi_min !== 5 || gen_i[2].hi_max !== 5 || gen_i[2].lo_min !== 5 || gen_i[2].lo_max !== 5) begin
      failures++; $display("FAIL div5_sck_width: hi %0d..%0d lo %0d..%0d expected all 5",
                           gen_i[2].hi_min, gen_i[2].hi_max, gen_i[2].lo_min, gen_i[2].lo_max); end
    checks++; if (gen_i[2].addr_cap !== 24'h000033) begin failures++; $display("FAIL div5_addr: got %h expected 000033", gen_i[2].addr_cap); end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      req_valid[i] = 1'b0; req_addr[i] = '0; rsp_ready[i] = 1'b1;
    end
    for (int a = 0; a < 1024; a++) mem[a] = 8'h00;
    mem[0]   = 8'h6F; mem[1]   = 8'h00; mem[2]   = 8'h00; mem[3]   = 8'h0B;
    mem[16]  = 8'hA1; mem[17]  = 8'hB2; mem[18]  = 8'hC3; mem[19]  = 8'hD4;
    mem[32]  = 8'h01; mem[33]  = 8'h23; mem[34]  = 8'h45; mem[35]  = 8'h67;
    mem[51]  = 8'hFE; mem[52]  = 8'hDC; mem[53]  = 8'hBA; mem[54]  = 8'h98;
    mem[501] = 8'h11; mem[502] = 8'h22; mem[503] = 8'h33; mem[504] = 8'h44;
    test_reset();
    test_single_read();
    test_unaligned();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_clk_div();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
